// File: rtl/game_pkg.sv
// Shared types, defaults and switch encoders for the unicorn runner sequencer.
// No timing of its own; everything here is constants and pure functions.
package game_pkg;

  localparam int DB_CYCLES_DEF      = 1_000_000;
  localparam int TICK_BITS_DEF      = 20;
  localparam int LOCKOUT_CYCLES_DEF = 50_000_000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DEAD = 2'd2
  } state_t;

  typedef struct packed {
    logic [2:0] speed;
    logic [1:0] difficulty;
  } settings_t;

  localparam settings_t SETTINGS_RST = '{speed: 3'd2, difficulty: 2'd0};

  function automatic logic [2:0] encode_speed(input logic [3:0] sw);
    if (sw[3])      return 3'd6;
    else if (sw[2]) return 3'd5;
    else if (sw[1]) return 3'd4;
    else if (sw[0]) return 3'd3;
    else            return 3'd2;
  endfunction

  function automatic logic [1:0] encode_difficulty(input logic [3:0] sw);
    if (sw[3])      return 2'd3;
    else if (sw[2]) return 2'd2;
    else if (sw[1]) return 2'd1;
    else            return 2'd0;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// Button conditioner: 2-flop synchronizer, stability debouncer, rising-edge press pulse.
// db follows btn 2+DB_CYCLES cycles after a clean change; no backpressure.
module btn_debounce #(
  parameter int DB_CYCLES = game_pkg::DB_CYCLES_DEF
) (
  input  logic CLK100MHZ,
  input  logic reset,
  input  logic btn,
  output logic db,
  output logic press
);

  localparam int CW = $clog2(DB_CYCLES + 1);

  logic          sync1;
  logic          sync2;
  logic [CW-1:0] cnt;
  logic          flip;

  // Flip on the DB_CYCLES-th consecutive cycle of disagreement.
  assign flip = (sync2 != db) && (cnt == CW'(DB_CYCLES - 1));

  always_ff @(posedge CLK100MHZ) begin
    if (reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      cnt   <= '0;
      db    <= 1'b0;
      press <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      press <= flip && sync2;
      if (flip) begin
        db  <= sync2;
        cnt <= '0;
      end else if (sync2 != db) begin
        cnt <= cnt + CW'(1);
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/game_sequencer.sv
// Game controller: IDLE/RUN/DEAD FSM, speed-scaled tick enable, latched settings, death lockout.
// All outputs registered, one cycle after the qualifying condition; no backpressure.
module game_sequencer
  import game_pkg::*;
#(
  parameter int DB_CYCLES      = DB_CYCLES_DEF,
  parameter int TICK_BITS      = TICK_BITS_DEF,
  parameter int LOCKOUT_CYCLES = LOCKOUT_CYCLES_DEF
) (
  input  logic       CLK100MHZ,
  input  logic       reset_btn,
  input  logic       jump_btn,
  input  logic [3:0] speed_in,
  input  logic [3:0] difficulty_in,
  input  logic       isdead,
  output logic       tick,
  output logic       start,
  output logic       jump,
  output logic [2:0] speed,
  output logic [1:0] difficulty,
  output logic       dead,
  output logic [1:0] state
);

  localparam int LW = $clog2(LOCKOUT_CYCLES + 1);

  logic db;
  logic press;

  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_jump_db (
    .CLK100MHZ (CLK100MHZ),
    .reset     (reset_btn),
    .btn       (jump_btn),
    .db        (db),
    .press     (press)
  );

  state_t             st;
  state_t             st_nxt;
  logic               armed;
  logic               armed_nxt;
  settings_t          cfg;
  logic [TICK_BITS-1:0] acc;
  logic [TICK_BITS:0] acc_sum;
  logic [LW-1:0]      lock_cnt;
  logic               lock_done;

  // Carry into bit TICK_BITS is the tick; only the low bits are kept.
  assign acc_sum   = {1'b0, acc} + {{(TICK_BITS - 2){1'b0}}, cfg.speed};
  assign lock_done = (lock_cnt == LW'(LOCKOUT_CYCLES));

  always_comb begin
    st_nxt    = st;
    armed_nxt = armed;
    case (st)
      IDLE: begin
        if (press) begin
          st_nxt    = RUN;
          armed_nxt = 1'b0;
        end
      end
      RUN: begin
        // The start press must be released before jumps count.
        if (!db) armed_nxt = 1'b1;
        if (isdead) st_nxt = DEAD;
      end
      DEAD: begin
        if (press && lock_done) st_nxt = IDLE;
      end
      default: st_nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset_btn) begin
      st    <= IDLE;
      armed <= 1'b0;
    end else begin
      st    <= st_nxt;
      armed <= armed_nxt;
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (reset_btn) begin
      start    <= 1'b0;
      dead     <= 1'b0;
      jump     <= 1'b0;
      tick     <= 1'b0;
      cfg      <= SETTINGS_RST;
      acc      <= '0;
      lock_cnt <= '0;
    end else begin
      start <= (st_nxt == RUN);
      dead  <= (st_nxt == DEAD);
      jump  <= (st_nxt == RUN) && armed_nxt && db;
      tick  <= 1'b0;
      if (st == IDLE && st_nxt == RUN) begin
        cfg <= '{speed: encode_speed(speed_in), difficulty: encode_difficulty(difficulty_in)};
        acc <= '0;
      end else if (st == RUN && st_nxt == RUN) begin
        acc  <= acc_sum[TICK_BITS-1:0];
        tick <= acc_sum[TICK_BITS];
      end
      if (st != DEAD) lock_cnt <= '0;
      else if (!lock_done) lock_cnt <= lock_cnt + LW'(1);
    end
  end

  assign speed      = cfg.speed;
  assign difficulty = cfg.difficulty;
  assign state      = st;

endmodule

// File: tb/tb_game_sequencer.sv
// Scoreboarded bench for game_sequencer: behavioural reference model feeds an expected-output
// queue each clock edge; a monitor pops and compares on the falling edge.
module tb_game_sequencer;

  localparam int DB     = 4;
  localparam int TB     = 4;
  localparam int LOCK   = 32;
  localparam int PERIOD = 1 << TB;

  logic       clk = 1'b0;
  logic       reset_btn;
  logic       jump_btn;
  logic [3:0] speed_in;
  logic [3:0] difficulty_in;
  logic       isdead;
  logic       tick, start, jump, dead;
  logic [2:0] speed;
  logic [1:0] difficulty;
  logic [1:0] state;

  game_sequencer #(.DB_CYCLES(DB), .TICK_BITS(TB), .LOCKOUT_CYCLES(LOCK)) dut (
    .CLK100MHZ     (clk),
    .reset_btn     (reset_btn),
    .jump_btn      (jump_btn),
    .speed_in      (speed_in),
    .difficulty_in (difficulty_in),
    .isdead        (isdead),
    .tick          (tick),
    .start         (start),
    .jump          (jump),
    .speed         (speed),
    .difficulty    (difficulty),
    .dead          (dead),
    .state         (state)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  logic [10:0] exp_q[$];

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Highest set switch wins.
  function automatic int enc_speed(input logic [3:0] sw);
    int s = 2;
    for (int i = 0; i < 4; i++) if (sw[i]) s = i + 3;
    return s;
  endfunction

  function automatic int enc_diff(input logic [3:0] sw);
    int d = 0;
    for (int i = 1; i < 4; i++) if (sw[i]) d = i;
    return d;
  endfunction

  // Reference model state
  logic [1:0] m_state;
  bit m_db, m_press, m_armed, m_tick, m_jump;
  int m_speed, m_diff, m_k, m_age;
  bit hist[$];
  bit mp, md, man, mall;
  logic [1:0] msn;

  initial forever begin
    @(posedge clk);
    if (reset_btn) begin
      m_state = 2'd0; m_db = 0; m_press = 0; m_armed = 0; m_tick = 0; m_jump = 0;
      m_speed = 2; m_diff = 0; m_k = 0; m_age = 0;
      hist.delete();
      for (int i = 0; i < DB + 2; i++) hist.push_back(1'b0);
    end else begin
      mp = m_press; md = m_db; man = m_armed; msn = m_state; m_tick = 0;
      case (m_state)
        2'd0: if (mp) begin
          msn = 2'd1; man = 0; m_k = 0;
          m_speed = enc_speed(speed_in); m_diff = enc_diff(difficulty_in);
        end
        2'd1: begin
          if (!md) man = 1;
          if (isdead) begin
            msn = 2'd2; m_age = 0;
          end else begin
            m_k++;
            m_tick = ((m_k * m_speed) / PERIOD) != (((m_k - 1) * m_speed) / PERIOD);
          end
        end
        default: begin
          if (mp && m_age >= LOCK) msn = 2'd0;
          else m_age++;
        end
      endcase
      m_jump  = (msn == 2'd1) && man && md;
      m_state = msn;
      m_armed = man;
      // db flips once the synchronized input has disagreed for DB samples in a row
      hist.push_back(jump_btn);
      void'(hist.pop_front());
      mall = 1;
      for (int i = 0; i < DB; i++) if (hist[i] == md) mall = 0;
      m_press = mall && !md;
      if (mall) m_db = !md;
    end
    exp_q.push_back({m_state, m_state == 2'd1, m_state == 2'd2, m_tick, m_jump,
                     3'(m_speed), 2'(m_diff)});
  end

  logic [10:0] mon_e, mon_a;
  initial forever begin
    @(negedge clk);
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      mon_a = {state, start, dead, tick, jump, speed, difficulty};
      n_cmp++;
      if (mon_a !== mon_e) begin
        n_bad++;
        $display("FAIL outputs @%0t: got %h expected %h", $time, mon_a, mon_e);
      end
    end
  end

  int lat, nt, hold;

  initial begin
    reset_btn = 1; jump_btn = 0; isdead = 0; speed_in = 0; difficulty_in = 0;
    cyc(3);
    reset_btn = 0;
    chk("rst_state", state, 0);  chk("rst_start", start, 0); chk("rst_dead", dead, 0);
    chk("rst_jump", jump, 0);    chk("rst_speed", speed, 2); chk("rst_diff", difficulty, 0);
    nt = 0;
    for (int i = 0; i < 100; i++) begin
      speed_in = 4'($urandom); cyc(1); nt += int'(tick);
    end
    chk("idle_ticks", nt, 0);
    chk("idle_state", state, 0);

    // Bounce rejection
    for (int i = 0; i < 10; i++) begin
      jump_btn = 1; cyc(3); jump_btn = 0; cyc(2);
    end
    cyc(8);
    chk("bounce_state", state, 0);

    // Start, latency, tick rate
    speed_in = 4'b0100; difficulty_in = 4'b0010;
    jump_btn = 1; lat = 0;
    for (int i = 1; i <= 12; i++) begin
      cyc(1);
      if (lat == 0 && start) lat = i;
    end
    jump_btn = 0;
    chk("start_latency", lat, 7);
    chk("run_speed", speed, 5);
    chk("run_diff", difficulty, 1);
    nt = 0;
    for (int i = 0; i < 16; i++) begin cyc(1); nt += int'(tick); end
    chk("ticks_per16_s5", nt, 5);

    // Latched settings
    speed_in = 4'b1000; difficulty_in = 4'b1000;
    cyc(3);
    chk("latched_speed", speed, 5);
    chk("latched_diff", difficulty, 1);

    // Re-press after release yields a jump
    cyc(10);
    jump_btn = 1; cyc(8);
    chk("jump_repress", jump, 1);
    jump_btn = 0; cyc(10);

    // Death coinciding with a press
    jump_btn = 1; cyc(6);
    isdead = 1; cyc(1); isdead = 0;
    chk("death_state", state, 2); chk("death_dead", dead, 1);
    chk("death_start", start, 0); chk("death_tick", tick, 0);
    jump_btn = 0; cyc(9);
    jump_btn = 1; cyc(8); jump_btn = 0;
    chk("lockout_ignore", state, 2);
    cyc(30);
    jump_btn = 1; cyc(8); jump_btn = 0;
    chk("lockout_release", state, 0);

    // Next run latches new switches
    cyc(10);
    jump_btn = 1; cyc(8); jump_btn = 0;
    chk("run2_state", state, 1);
    chk("run2_speed", speed, 6);
    chk("run2_diff", difficulty, 3);
    cyc(4);
    nt = 0;
    for (int i = 0; i < 16; i++) begin cyc(1); nt += int'(tick); end
    chk("ticks_per16_s6", nt, 6);

    // Mid-run reset
    reset_btn = 1; cyc(1); reset_btn = 0;
    chk("mrst_state", state, 0); chk("mrst_start", start, 0);
    chk("mrst_speed", speed, 2); chk("mrst_diff", difficulty, 0);
    nt = 0;
    for (int i = 0; i < 30; i++) begin cyc(1); nt += int'(tick); end
    chk("mrst_ticks", nt, 0);

    // Randomized traffic against the model
    hold = 0;
    for (int i = 0; i < 3000; i++) begin
      if (hold == 0) begin
        jump_btn = 1'($urandom);
        hold = $urandom_range(1, 12);
      end
      hold--;
      isdead    = ($urandom % 40) == 0;
      reset_btn = ($urandom % 400) == 0;
      if (($urandom % 50) == 0) begin
        speed_in = 4'($urandom); difficulty_in = 4'($urandom);
      end
      cyc(1);
    end
    reset_btn = 0; isdead = 0; jump_btn = 0;
    cyc(3);
    chk("sb_drain", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/game_sequencer.md
# game_sequencer

Central controller for the unicorn runner. Conditions the raw jump button, runs the IDLE/RUN/DEAD game state machine, and latches speed and difficulty at run start. Replaces the derived divided clock with a single-cycle `tick` enable, generated by a speed-scaled phase accumulator on CLK100MHZ. The physics, map, score and audio engines all consume its `start`, `tick`, `jump`, `speed` and `difficulty` outputs.

## Interface
Parameters:
- DB_CYCLES, 1_000_000: consecutive stable cycles required to accept a button level change (10 ms).
- TICK_BITS, 20: accumulator carry bit; tick period is 2^TICK_BITS / speed cycles.
- LOCKOUT_CYCLES, 50_000_000: presses ignored for this many cycles after entering DEAD.

Ports:
- CLK100MHZ  in  1  system clock, the only clock.
- reset_btn  in  1  synchronous, active-high reset.
- jump_btn  in  1  raw asynchronous button.
- speed_in  in  4  speed switches, priority-encoded.
- difficulty_in  in  4  difficulty switches, priority-encoded.
- isdead  in  1  collision flag from the physics engine.
- tick  out  1  one-cycle game-step enable.
- start  out  1  high while in RUN.
- jump  out  1  debounced, armed jump level.
- speed  out  3  latched speed, 2..6.
- difficulty  out  2  latched difficulty, 0..3.
- dead  out  1  high while in DEAD.
- state  out  2  IDLE=0, RUN=1, DEAD=2.

## Operation
- **Input conditioning:** jump_btn passes through a 2-flop synchronizer, then the debouncer. The debounced level `db` flips only after the synchronized input differs from `db` for DB_CYCLES consecutive cycles. Any mismatch-free cycle clears the counter. `press` is a one-cycle pulse on the rising edge of `db`.
- **Speed encoding:** speed_in[3]→6, [2]→5, [1]→4, [0]→3, none→2.
- **Difficulty encoding:** difficulty_in[3]→3, [2]→2, [1]→1, none→0.
- Both encoded values are captured only on the IDLE→RUN transition and held constant for the whole run.
- **IDLE:** outputs start=0, dead=0, tick=0. On `press`, go to RUN, latch speed and difficulty, clear the accumulator, and clear `armed`.
- **RUN:** outputs start=1.
  - The accumulator (TICK_BITS+1 bits) adds the latched speed every cycle. `tick` = carry out of bit TICK_BITS−1; after a tick the accumulator keeps the low TICK_BITS bits.
  - `armed` sets on the first cycle with db=0, so the start press is never treated as a jump.
  - jump = db & armed & RUN.
  - isdead=1 on any cycle → DEAD.
- **DEAD:** outputs start=0, dead=1, tick=0, jump=0.
  - The lockout counter counts up to LOCKOUT_CYCLES; `press` is ignored until it saturates.
  - A `press` after saturation → IDLE. The game then needs another press to start.
- **Priority:** reset_btn beats everything. In RUN, isdead beats press.
- **Reset values:** state=IDLE, tick=0, start=0, jump=0, dead=0, speed=2, difficulty=0, and the accumulator, debounce counter, lockout counter, db and armed are all 0.

## Timing
- All outputs are registered. State and outputs change on the CLK100MHZ edge after the qualifying condition.
- **Press latency:** jump_btn rise → `db` rise takes 2 (sync) + DB_CYCLES cycles; start=1 one cycle later.
- **First tick:** occurs ceil(2^TICK_BITS / speed) cycles after RUN entry. Exactly `speed` ticks occur per 2^TICK_BITS cycles. tick is never high on two consecutive cycles (speed ≤ 6 < 2^TICK_BITS).
- **isdead response:** isdead high in cycle n gives start=0 and dead=1 in cycle n+1. A tick already due in n+1 is suppressed.
- **Mid-operation reset:** reset_btn high in cycle n gives reset values in cycle n+1, with no ticks from n+1 onward.
- **Lockout wrap:** the lockout counter saturates and does not wrap. It clears on DEAD entry.

## Structure
- Shared package `game_pkg`:
  - state encoding constants (IDLE, RUN, DEAD);
  - speed and difficulty encode functions;
  - the default values of DB_CYCLES, TICK_BITS and LOCKOUT_CYCLES.
- One sub-module, `btn_debounce`, containing the synchronizer, debounce counter, `db` and `press`. It is parameterized by DB_CYCLES and reused for reset_btn conditioning elsewhere.
- The state machine, accumulator and lockout counter live in `game_sequencer` itself.

## Test plan
All scenarios use DB_CYCLES=4, TICK_BITS=4, LOCKOUT_CYCLES=32.
- **Reset and idle:** hold reset_btn 3 cycles, then idle 100 cycles → state=0, every output at its reset value, tick never asserted.
- **Start and tick rate:** speed_in=4'b0100, difficulty_in=4'b0010, jump_btn high for 12 cycles → start=1 seven cycles after the rise, speed=5, difficulty=1, exactly 5 ticks per 16 cycles, and jump stays 0 until release and re-press.
- **Bounce rejection:** jump_btn pulses of 3 high / 2 low, repeated → db never rises, state stays IDLE.
- **Death with simultaneous press:** in RUN, assert isdead and a press pulse in the same cycle → next cycle state=2, dead=1, start=0, tick stops. A press 10 cycles later is ignored. A press after 32 cycles → IDLE.
- **Latched settings:** in RUN, change speed_in to 4'b1000 and difficulty_in to 4'b1000 → speed stays 5 and difficulty stays 1. The next run latches 6 and 3.
- **Mid-run reset:** assert reset_btn for one cycle in RUN → the next cycle shows reset values and no further ticks.
